// File: rtl/morse_element_sequencer.sv
// Morse keyer: turns one captured character (dot/dash pattern) or a word space
// into a timed key waveform built from UNIT_CYCLES-long time units.
module morse_element_sequencer #(
  parameter int UNIT_CYCLES = 50000,
  parameter int MAX_LEN     = 6
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               valid,
  input  logic [MAX_LEN-1:0] code,
  input  logic [2:0]         len,
  input  logic               abort,
  output logic               ready,
  output logic               key,
  output logic               done,
  output logic               busy
);

  localparam int             PW         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(UNIT_CYCLES - 1);
  localparam logic [2:0]     LEN_MAX    = 3'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, MARK, GAP, CHAR_GAP, WORD_GAP} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      presc;
  logic [2:0]         unit_cnt;
  logic [2:0]         idx;
  logic [MAX_LEN-1:0] code_r;
  logic [2:0]         len_r;
  logic [7:0]         code_pad;
  logic [2:0]         dur;
  logic               accept;
  logic               unit_done;
  logic               done_nxt;

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  assign code_pad = 8'(code_r);
  assign ready    = (state == IDLE);
  assign busy     = ~ready;

  always_comb begin
    dur = 3'd1;
    case (state)
      MARK:     dur = code_pad[idx] ? 3'd3 : 3'd1;
      GAP:      dur = 3'd1;
      CHAR_GAP: dur = 3'd3;
      WORD_GAP: dur = 3'd7;
      default:  dur = 3'd1;
    endcase
  end

  assign unit_done = (presc == PRESC_LAST) && (unit_cnt == dur - 3'd1);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // valid takes priority over abort here since abort only cancels work in progress
        if (valid) begin
          accept    = 1'b1;
          state_nxt = (clamp_len(len) == 3'd0) ? WORD_GAP : MARK;
        end
      end
      MARK: begin
        if (unit_done) state_nxt = (idx == len_r - 3'd1) ? CHAR_GAP : GAP;
      end
      GAP: begin
        if (unit_done) state_nxt = MARK;
      end
      CHAR_GAP, WORD_GAP: begin
        if (unit_done) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      key   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      key   <= (state_nxt == MARK);
      done  <= done_nxt;
    end
  end

  // Unit timing restarts from zero on every state entry
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      presc    <= '0;
      unit_cnt <= '0;
    end else if (state_nxt != state) begin
      presc    <= '0;
      unit_cnt <= '0;
    end else if (state != IDLE) begin
      if (presc == PRESC_LAST) begin
        presc    <= '0;
        unit_cnt <= unit_cnt + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      idx    <= '0;
      code_r <= '0;
      len_r  <= '0;
    end else if (accept) begin
      idx    <= '0;
      code_r <= code;
      len_r  <= clamp_len(len);
    end else if ((state == GAP) && (state_nxt == MARK)) begin
      idx <= idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_morse_element_sequencer.sv
// Directed bench for morse_element_sequencer: a per-cycle expected waveform
// queue is filled when a character is sent and drained against the DUT.
module tb_morse_element_sequencer;

  localparam int U  = 4;
  localparam int ML = 6;

  logic          clk = 1'b0;
  logic          areset;
  logic          valid;
  logic [ML-1:0] code;
  logic [2:0]    len;
  logic          abort;
  logic          ready, key, done, busy;

  typedef struct packed {
    logic k;
    logic r;
    logic d;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   done_at = -1;
  int   t0      = 0;
  int   t_first = 0;
  bit   spam     = 1'b0;
  bit   scramble = 1'b0;

  morse_element_sequencer #(.UNIT_CYCLES(U), .MAX_LEN(ML)) dut (
    .clk    (clk),
    .areset (areset),
    .valid  (valid),
    .code   (code),
    .len    (len),
    .abort  (abort),
    .ready  (ready),
    .key    (key),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected the bench to finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_e(input logic k, input logic r, input logic d);
    exp_t e;
    e.k = k; e.r = r; e.d = d;
    q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_e(1'b0, 1'b1, 1'b0);
  endtask

  task automatic push_busy(input logic k, input int n);
    for (int i = 0; i < n; i++) push_e(k, 1'b0, 1'b0);
  endtask

  // Expected waveform from Morse timing rules: dot 1, dash 3, gap 1, char gap 3, word 7 units
  task automatic push_char(input logic [ML-1:0] c, input logic [2:0] l);
    int n;
    n = (int'(l) > ML) ? ML : int'(l);
    if (n == 0) begin
      push_busy(1'b0, 7 * U);
    end else begin
      for (int i = 0; i < n; i++) begin
        push_busy(1'b1, (c[i] ? 3 : 1) * U);
        push_busy(1'b0, (i < n - 1) ? U : 3 * U);
      end
    end
    push_e(1'b0, 1'b1, 1'b1);
  endtask

  task automatic send(input logic [ML-1:0] c, input logic [2:0] l);
    code  = c;
    len   = l;
    valid = 1'b1;
    t0    = cyc;
    push_char(c, l);
  endtask

  task automatic check_cycle();
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL queue_empty cyc=%0d got=empty exp=entry", cyc);
      e.k = 1'b0; e.r = 1'b1; e.d = 1'b0;
    end else begin
      e = q.pop_front();
    end
    chk("key", key, e.k);
    chk("ready", ready, e.r);
    chk("busy", busy, ~e.r);
    chk("done", done, e.d);
    if (done === 1'b1) done_at = cyc;
    cyc++;
    @(posedge clk);
    #1;
    valid = spam && (q.size() > 1);
    if (scramble) begin
      code = ML'($urandom);
      len  = 3'($urandom);
    end
  endtask

  task automatic drain();
    while (q.size() > 1) check_cycle();
  endtask

  initial begin
    areset = 1'b1;
    valid  = 1'b0;
    abort  = 1'b0;
    code   = '0;
    len    = '0;
    #2;
    chk("rst_key", key, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    areset = 1'b0;

    // Letter A directly after reset release
    push_idle(1);
    send(6'b000010, 3'd2);
    drain();
    check_cycle();
    chk_int("A_done_cycle", done_at - t0, 33);

    // Word space
    push_idle(1);
    send(6'b000000, 3'd0);
    drain();
    check_cycle();
    chk_int("word_done_cycle", done_at - t0, 29);

    // E then T back to back, T offered in the E done cycle
    push_idle(1);
    send(6'b000000, 3'd1);
    t_first = t0;
    drain();
    send(6'b000001, 3'd1);
    check_cycle();
    chk_int("E_done_cycle", done_at - t_first, 17);
    drain();
    check_cycle();
    chk_int("T_done_cycle", done_at - t_first, 42);

    // len=7 clamps to six dashes
    push_idle(1);
    send(6'b111111, 3'd7);
    drain();
    check_cycle();
    chk_int("clamp_done_cycle", done_at - t0, 105);

    // Bits above len ignored; inputs scrambled and valid held while busy
    push_idle(1);
    scramble = 1'b1;
    spam     = 1'b1;
    send(6'b111100, 3'd2);
    drain();
    spam = 1'b0;
    check_cycle();
    scramble = 1'b0;
    chk_int("ignore_done_cycle", done_at - t0, 25);

    // Abort during the dash of letter A at cycle 10
    push_idle(1);
    send(6'b000010, 3'd2);
    for (int i = 0; i < 10; i++) check_cycle();
    abort = 1'b1;
    q.delete();
    push_e(1'b1, 1'b0, 1'b0);
    push_idle(5);
    done_at = -1;
    check_cycle();
    abort = 1'b0;
    for (int i = 0; i < 5; i++) check_cycle();
    chk_int("abort_no_done", done_at, -1);

    // abort together with valid in IDLE: request still accepted
    push_idle(1);
    abort = 1'b1;
    send(6'b000000, 3'd1);
    check_cycle();
    abort = 1'b0;
    drain();
    check_cycle();
    chk_int("abort_idle_done_cycle", done_at - t0, 17);

    // Asynchronous reset pulse mid-MARK, then accept on the first edge
    push_idle(1);
    send(6'b000001, 3'd1);
    for (int i = 0; i < 3; i++) check_cycle();
    #1;
    areset = 1'b1;
    #1;
    chk("async_rst_key", key, 1'b0);
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    areset = 1'b0;
    q.delete();
    push_idle(1);
    send(6'b000000, 3'd1);
    drain();
    check_cycle();
    chk_int("post_rst_done_cycle", done_at - t0, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
